// File: rtl/matmul_nxn_engine.sv
// N x N signed matrix-multiply engine built on an output-stationary systolic PE grid.
// The operands are captured when a job starts. Results stay on c_matrix behind a valid/ready handshake.
module matmul_nxn_engine #(
    parameter int N        = 8,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    start_ready,
    input  logic                    acc_mode,
    input  logic [N*N*DATA_W-1:0]   a_matrix,
    input  logic [N*N*DATA_W-1:0]   b_matrix,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*N*ACC_W-1:0]    c_matrix,
    output logic                    overflow
);

    localparam int                CNT_W    = $clog2(3 * N);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(3 * N - 3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_OUT
    } state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_start_ready;
    logic                       r_out_valid;
    logic                       r_overflow;
    logic [N*N*DATA_W-1:0]      r_a_op;
    logic [N*N*DATA_W-1:0]      r_b_op;

    logic                       w_accept;
    logic                       w_compute;
    logic [N*N-1:0]             w_ovf_bits;
    logic signed [DATA_W-1:0]   w_left [N];
    logic signed [DATA_W-1:0]   w_top  [N];
    logic signed [DATA_W-1:0]   w_a_out [N][N];
    logic signed [DATA_W-1:0]   w_b_out [N][N];

    assign w_accept    = start && r_start_ready;
    assign w_compute   = (r_state == S_COMPUTE);
    assign start_ready = r_start_ready;
    assign out_valid   = r_out_valid;
    assign overflow    = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_op <= '0;
            r_b_op <= '0;
        end else if (w_accept) begin
            r_a_op <= a_matrix;
            r_b_op <= b_matrix;
        end
    end

    // Skewed edge feed. Row i and column j see operand k on cycle cnt = i+k (or j+k), and zero outside that window.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_left[i] = '0;
            w_top[i]  = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(r_cnt) == i + k) begin
                    w_left[i] = r_a_op[(i*N+k)*DATA_W +: DATA_W];
                    w_top[i]  = r_b_op[(k*N+i)*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [DATA_W-1:0]   w_a_in;
            logic signed [DATA_W-1:0]   w_b_in;
            logic signed [DATA_W-1:0]   r_a;
            logic signed [DATA_W-1:0]   r_b;
            logic signed [ACC_W-1:0]    r_acc;
            logic signed [ACC_W-1:0]    w_next;
            logic signed [2*DATA_W-1:0] w_a_ext;
            logic signed [2*DATA_W-1:0] w_b_ext;
            logic signed [2*DATA_W-1:0] w_prod;
            logic signed [ACC_W:0]      w_sum;
            logic                       w_ovf;

            if (gj == 0) begin : g_a_edge
                assign w_a_in = w_left[gi];
            end else begin : g_a_pass
                assign w_a_in = w_a_out[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign w_b_in = w_top[gj];
            end else begin : g_b_pass
                assign w_b_in = w_b_out[gi-1][gj];
            end

            assign w_a_ext = {{DATA_W{w_a_in[DATA_W-1]}}, w_a_in};
            assign w_b_ext = {{DATA_W{w_b_in[DATA_W-1]}}, w_b_in};
            assign w_prod  = w_a_ext * w_b_ext;

            // One spare bit holds the exact sum. Overflow means the top two bits disagree.
            assign w_sum = {r_acc[ACC_W-1], r_acc}
                         + {{(ACC_W + 1 - 2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
            assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

            if (SATURATE != 0) begin : g_sat
                assign w_next = !w_ovf ? w_sum[ACC_W-1:0]
                              : (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}});
            end else begin : g_wrap
                assign w_next = w_sum[ACC_W-1:0];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_acc <= '0;
                end else if (w_accept) begin
                    r_a <= '0;
                    r_b <= '0;
                    if (!acc_mode) begin
                        r_acc <= '0;
                    end
                end else if (w_compute) begin
                    r_a   <= w_a_in;
                    r_b   <= w_b_in;
                    r_acc <= w_next;
                end
            end

            assign w_a_out[gi][gj]                       = r_a;
            assign w_b_out[gi][gj]                       = r_b;
            assign w_ovf_bits[gi*N+gj]                   = w_ovf;
            assign c_matrix[(gi*N+gj)*ACC_W +: ACC_W]    = r_acc;
        end
    end

    // The last PE takes its final operand pair when cnt = 3N-3, so OUT follows on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_start_ready <= 1'b1;
            r_out_valid   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state       <= S_COMPUTE;
                        r_cnt         <= '0;
                        r_start_ready <= 1'b0;
                        r_overflow    <= 1'b0;
                    end
                end
                S_COMPUTE: begin
                    r_overflow <= r_overflow | (|w_ovf_bits);
                    if (r_cnt == LAST_CNT) begin
                        r_state     <= S_OUT;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state       <= S_IDLE;
                        r_out_valid   <= 1'b0;
                        r_start_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_nxn_engine.sv
// Testbench for matmul_nxn_engine. It drives two N=8 instances (wrap and saturate) and one N=2 instance.
// All results are checked against a per-element sequential multiply-accumulate reference.
module tb_matmul_nxn_engine;

    localparam int N8 = 8;
    localparam int N2 = 2;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int ACC_MAX = 32767;
    localparam int ACC_MIN = -32768;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                    start8, mode8, ready8;
    logic [N8*N8*DW-1:0]     a8, b8;
    logic                    startReadyW, validW, ovfW;
    logic                    startReadyS, validS, ovfS;
    logic [N8*N8*AW-1:0]     cMatW, cMatS;

    logic                    start2, mode2, ready2;
    logic [N2*N2*DW-1:0]     a2, b2;
    logic                    startReady2, valid2, ovf2;
    logic [N2*N2*AW-1:0]     cMat2;

    matmul_nxn_engine #(.N(N8), .DATA_W(DW), .ACC_W(AW), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .start(start8), .start_ready(startReadyW),
        .acc_mode(mode8), .a_matrix(a8), .b_matrix(b8), .out_valid(validW),
        .out_ready(ready8), .c_matrix(cMatW), .overflow(ovfW)
    );

    matmul_nxn_engine #(.N(N8), .DATA_W(DW), .ACC_W(AW), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .start(start8), .start_ready(startReadyS),
        .acc_mode(mode8), .a_matrix(a8), .b_matrix(b8), .out_valid(validS),
        .out_ready(ready8), .c_matrix(cMatS), .overflow(ovfS)
    );

    matmul_nxn_engine #(.N(N2), .DATA_W(DW), .ACC_W(AW), .SATURATE(0)) u_n2 (
        .clk(clk), .reset(reset), .start(start2), .start_ready(startReady2),
        .acc_mode(mode2), .a_matrix(a2), .b_matrix(b2), .out_valid(valid2),
        .out_ready(ready2), .c_matrix(cMat2), .overflow(ovf2)
    );

    typedef enum int {K_IDENT, K_RAMP, K_ALL127, K_RAND, K_NEG128} kind_t;

    typedef struct {
        kind_t aKind;
        kind_t bKind;
        bit    mode;
        bit    scramble;
        int    expLat;
        bit    expOvW;
        bit    expOvS;
    } vec_t;

    vec_t vecs [7];

    int mA  [8][8];
    int mB  [8][8];
    int mCW [8][8];
    int mCS [8][8];
    bit mOvW, mOvS;

    int nCompared = 0;
    int nFailed   = 0;

    task automatic checkOutput(input string name, input int got, input int exp);
        nCompared++;
        if (got != exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int kindVal(input kind_t k, input int r, input int c);
        case (k)
            K_IDENT:  return (r == c) ? 1 : 0;
            K_RAMP:   return r * 8 + c;
            K_ALL127: return 127;
            K_NEG128: return -128;
            default:  return int'($urandom_range(30)) - 15;
        endcase
    endfunction

    task automatic fillOps(input kind_t ak, input kind_t bk);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                mA[r][c] = kindVal(ak, r, c);
                mB[r][c] = kindVal(bk, r, c);
            end
        end
    endtask

    // Reference: every element is a dot product taken in order k = 0..N-1.
    // After each step, an out-of-range sum is either wrapped or clamped.
    task automatic modelJob(input bit mode);
        int p, e;
        mOvW = 1'b0;
        mOvS = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (!mode) begin
                    mCW[r][c] = 0;
                    mCS[r][c] = 0;
                end
                for (int k = 0; k < 8; k++) begin
                    p = mA[r][k] * mB[k][c];
                    e = mCW[r][c] + p;
                    if (e > ACC_MAX || e < ACC_MIN) mOvW = 1'b1;
                    while (e > ACC_MAX) e -= 65536;
                    while (e < ACC_MIN) e += 65536;
                    mCW[r][c] = e;
                    e = mCS[r][c] + p;
                    if (e > ACC_MAX) begin
                        mOvS = 1'b1;
                        e = ACC_MAX;
                    end else if (e < ACC_MIN) begin
                        mOvS = 1'b1;
                        e = ACC_MIN;
                    end
                    mCS[r][c] = e;
                end
            end
        end
    endtask

    task automatic driveOps8();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                a8[(r*8+c)*8 +: 8] = 8'(mA[r][c]);
                b8[(r*8+c)*8 +: 8] = 8'(mB[r][c]);
            end
        end
    endtask

    function automatic int elemW(input int r, input int c);
        return int'($signed(cMatW[(r*8+c)*16 +: 16]));
    endfunction

    function automatic int elemS(input int r, input int c);
        return int'($signed(cMatS[(r*8+c)*16 +: 16]));
    endfunction

    task automatic applyStimulus(input bit mode, input bit scramble, output int lat);
        driveOps8();
        mode8 = mode;
        checkOutput("start_ready_idle_w", int'(startReadyW), 1);
        checkOutput("start_ready_idle_s", int'(startReadyS), 1);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        mode8  = ~mode;
        lat    = 0;
        for (int e = 0; e < 100; e++) begin
            if (scramble) begin
                for (int w = 0; w < 16; w++) begin
                    a8[w*32 +: 32] = $urandom();
                    b8[w*32 +: 32] = $urandom();
                end
            end
            @(posedge clk); #1;
            lat++;
            if (validW || validS) break;
        end
    endtask

    task automatic checkResults8(input string tag);
        checkOutput({tag, "_ovf_w_model"}, int'(ovfW), int'(mOvW));
        checkOutput({tag, "_ovf_s_model"}, int'(ovfS), int'(mOvS));
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                checkOutput($sformatf("%s_cw_%0d_%0d", tag, r, c), elemW(r, c), mCW[r][c]);
                checkOutput($sformatf("%s_cs_%0d_%0d", tag, r, c), elemS(r, c), mCS[r][c]);
            end
        end
    endtask

    task automatic handshake8();
        ready8 = 1'b1;
        @(posedge clk); #1;
        ready8 = 1'b0;
        checkOutput("hs_valid_drop", int'(validW), 0);
        checkOutput("hs_start_ready", int'(startReadyW), 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int a2v [4];
        int b2v [4];
        int c2exp [4];
        logic [N8*N8*AW-1:0] snapW, snapS;

        vecs[0] = '{K_IDENT,  K_RAMP,   1'b0, 1'b0, 22, 1'b0, 1'b0};
        vecs[1] = '{K_IDENT,  K_RAMP,   1'b1, 1'b0, 22, 1'b0, 1'b0};
        vecs[2] = '{K_ALL127, K_ALL127, 1'b0, 1'b0, 22, 1'b1, 1'b1};
        vecs[3] = '{K_RAND,   K_RAND,   1'b0, 1'b1, 22, 1'b0, 1'b0};
        vecs[4] = '{K_RAND,   K_RAND,   1'b1, 1'b1, 22, 1'b0, 1'b0};
        vecs[5] = '{K_NEG128, K_ALL127, 1'b0, 1'b0, 22, 1'b1, 1'b1};
        vecs[6] = '{K_ALL127, K_ALL127, 1'b1, 1'b0, 22, 1'b1, 1'b1};
        a2v   = '{1, 2, 3, 4};
        b2v   = '{5, 6, 7, 8};
        c2exp = '{19, 22, 43, 50};

        reset  = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; ready8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; mode2 = 1'b0; ready2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        checkOutput("rst_start_ready", int'(startReadyW), 1);
        checkOutput("rst_valid", int'(validW), 0);
        checkOutput("rst_ovf", int'(ovfW), 0);
        checkOutput("rst_c_zero", int'(cMatW == '0 && cMatS == '0 && cMat2 == '0), 1);
        checkOutput("rst_start_ready_n2", int'(startReady2), 1);

        // 2x2 product with hand-computed constants.
        for (int i = 0; i < 4; i++) begin
            a2[i*8 +: 8] = 8'(a2v[i]);
            b2[i*8 +: 8] = 8'(b2v[i]);
        end
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            lat++;
            if (valid2) break;
        end
        checkOutput("n2_latency", lat, 4);
        checkOutput("n2_ovf", int'(ovf2), 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("n2_c_%0d", i), int'($signed(cMat2[i*16 +: 16])), c2exp[i]);
        end
        ready2 = 1'b1;
        @(posedge clk); #1;
        ready2 = 1'b0;
        checkOutput("n2_hs_valid", int'(valid2), 0);
        checkOutput("n2_hs_start_ready", int'(startReady2), 1);

        for (int v = 0; v < 7; v++) begin
            fillOps(vecs[v].aKind, vecs[v].bKind);
            modelJob(vecs[v].mode);
            applyStimulus(vecs[v].mode, vecs[v].scramble, lat);
            checkOutput($sformatf("v%0d_latency", v), lat, vecs[v].expLat);
            checkOutput($sformatf("v%0d_valid_w", v), int'(validW), 1);
            checkOutput($sformatf("v%0d_valid_s", v), int'(validS), 1);
            checkOutput($sformatf("v%0d_ovf_w", v), int'(ovfW), int'(vecs[v].expOvW));
            checkOutput($sformatf("v%0d_ovf_s", v), int'(ovfS), int'(vecs[v].expOvS));
            checkResults8($sformatf("v%0d", v));
            if (v == 1) checkOutput("acc_double_7_7", elemW(7, 7), 126);
            if (v == 2) begin
                checkOutput("wrap127_3_5", elemW(3, 5), -2040);
                checkOutput("sat127_3_5", elemS(3, 5), 32767);
            end
            handshake8();
        end

        // Backpressure: the result must hold while out_ready is low, and start pulses must be ignored.
        fillOps(K_RAND, K_RAND);
        modelJob(1'b0);
        applyStimulus(1'b0, 1'b0, lat);
        checkOutput("bp_latency", lat, 22);
        snapW = cMatW;
        snapS = cMatS;
        for (int cyc = 0; cyc < 10; cyc++) begin
            start8 = (cyc == 2 || cyc == 6);
            @(posedge clk); #1;
            checkOutput("bp_valid", int'(validW), 1);
            checkOutput("bp_start_ready", int'(startReadyW), 0);
            checkOutput("bp_c_hold", int'(cMatW == snapW && cMatS == snapS), 1);
        end
        start8 = 1'b1;
        ready8 = 1'b1;
        @(posedge clk); #1;
        ready8 = 1'b0;
        start8 = 1'b0;
        checkOutput("bp_hs_valid", int'(validW), 0);
        checkOutput("bp_hs_start_ready", int'(startReadyW), 1);
        checkResults8("bp");
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("bp_idle_start_ready", int'(startReadyW), 1);
            checkOutput("bp_idle_valid", int'(validW), 0);
        end

        // Reset asserted at cnt=10 aborts the job. A following accumulate job must start from zero.
        fillOps(K_RAND, K_RAND);
        driveOps8();
        mode8  = 1'b1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", int'(validW), 0);
        checkOutput("mid_rst_start_ready", int'(startReadyW), 1);
        checkOutput("mid_rst_ovf", int'(ovfW | ovfS), 0);
        checkOutput("mid_rst_c_zero", int'(cMatW == '0 && cMatS == '0), 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                mCW[r][c] = 0;
                mCS[r][c] = 0;
            end
        end
        fillOps(K_IDENT, K_RAMP);
        modelJob(1'b1);
        applyStimulus(1'b1, 1'b0, lat);
        checkOutput("post_rst_latency", lat, 22);
        checkResults8("post_rst");
        checkOutput("post_rst_c_2_3", elemW(2, 3), 19);
        handshake8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/matmul_nxn_engine.md
Name: matmul_nxn_engine

Overview:
- Parametrised N×N signed matrix-multiply engine that computes C = A·B, or C += A·B in accumulate mode.
- Contains its own output-stationary systolic PE grid and the skew-feed sequencer.
- Operands are captured on a start handshake; results are held behind a valid/ready output handshake.
- Sits between the host/DMA operand buffers and the result writeback path. It is the generalised successor to the fixed 8×8 top: adds job handshake, accumulate mode, saturation and an overflow flag.

Parameters:
- N, 8, matrix dimension (2..16)
- DATA_W, 8, signed operand element width
- ACC_W, 16, signed accumulator/result element width; must be ≥ 2*DATA_W
- SATURATE, 0, 0 = two's-complement wrap on overflow, 1 = clamp to signed ACC_W limits

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  job request; accepted when start && start_ready
- start_ready  out  1  high only in IDLE
- acc_mode  in  1  sampled at accept; 0 = clear C first, 1 = accumulate onto held C
- a_matrix  in  N*N*DATA_W  A, row-major; element (r,c) at [(r*N+c)*DATA_W +: DATA_W]
- b_matrix  in  N*N*DATA_W  B, same packing as A
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- c_matrix  out  N*N*ACC_W  C, row-major; element (r,c) at [(r*N+c)*ACC_W +: ACC_W]
- overflow  out  1  sticky per job; some accumulator exceeded the ACC_W range

Behaviour:
- Reset: clk domain; reset is asynchronous, active-high. State goes to IDLE. start_ready=1, out_valid=0, overflow=0, c_matrix=0, all PE pipeline registers=0, cycle counter=0.
- States: IDLE, COMPUTE, OUT.
  - IDLE→COMPUTE on start && start_ready.
  - COMPUTE→OUT when cnt==3N-3.
  - OUT→IDLE on out_valid && out_ready.
- Accept edge:
  - a_matrix and b_matrix latch into internal operand registers; later input changes have no effect on the job.
  - cnt clears to 0 and PE operand pipeline registers clear to 0.
  - overflow clears.
  - If acc_mode=0, all accumulators clear to 0; if acc_mode=1, they are kept.
- Skew feed during COMPUTE, with cnt running 0..3N-3:
  - Row i left input = A[i][cnt-i] when i ≤ cnt ≤ i+N-1, else 0.
  - Column j top input = B[cnt-j][j] when j ≤ cnt ≤ j+N-1, else 0.
  - Each PE registers its A value to the right and its B value downward, one cycle per hop.
- PE(i,j) MAC: acc += a*b with a signed 2*DATA_W product, sign-extended to ACC_W. Update is enabled only in COMPUTE; accumulators hold in IDLE and OUT.
- Overflow handling:
  - Detection: the exact sum lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any detection sets the overflow flag.
  - SATURATE=1: the accumulator clamps to the violated limit.
  - SATURATE=0: the accumulator wraps modulo 2^ACC_W.
- Latency: out_valid rises exactly 3N-2 rising edges after the accept edge (N=8: 22; N=2: 4). c_matrix is final and overflow is final when out_valid rises.
- OUT state:
  - out_valid=1; c_matrix and overflow are held stable until the handshake.
  - out_ready may stay low indefinitely.
  - On the handshake, out_valid drops on the next edge and start_ready rises on the same edge.
  - A start cannot be accepted in the handshake cycle.
- start while start_ready=0 is ignored and not queued. acc_mode is ignored outside the accept cycle.
- c_matrix always reflects the accumulators. It shows intermediate values during COMPUTE and is valid only while out_valid=1.
- Reset mid-COMPUTE or mid-OUT: the job is aborted immediately, with all outputs at reset values. The next accepted job behaves as if from power-up.

Test Plan:
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], acc_mode=0 → C=[[19,22],[43,50]]; out_valid exactly 4 edges after accept; overflow=0.
- N=8, A=identity, B[r][c]=r*8+c, acc_mode=0 → C=B; out_valid exactly 22 edges after accept. Then repeat with acc_mode=1 and new operands A=I, B unchanged → C[r][c]=2*(r*8+c).
- N=8, ACC_W=16, A=B=all 127:
  - SATURATE=1 → every C element=32767, overflow=1.
  - SATURATE=0 → every C element=-2040, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in OUT and pulse start twice during that time → out_valid stays 1, c_matrix is unchanged, start_ready=0 and no job is accepted. After the handshake, start_ready=1 on the next edge.
- Operand isolation: change a_matrix and b_matrix on every cycle after accept → result equals the product of the values captured at accept.
- Reset asserted at cnt=10 → out_valid=0, c_matrix=0, overflow=0, start_ready=1. Then a subsequent N=8 identity job with acc_mode=1 → C=B, proving the accumulators were cleared by reset.
